// File: rtl/mem_port_arbiter.sv
// Shares one RAM port between instruction fetch and the data-access stage.
// The data side has fixed priority; fetch is forced through after StarveLimit consecutive losses.
module mem_port_arbiter #(
  parameter int DataWidth   = 32,
  parameter int AddrWidth   = 32,
  parameter int WordSize    = 4,
  parameter int StarveLimit = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 if_req,
  input  logic [AddrWidth-1:0] if_address,
  output logic                 if_ready,
  output logic [DataWidth-1:0] if_read_data,
  input  logic                 mem_req,
  input  logic                 mem_write_enable,
  input  logic [AddrWidth-1:0] mem_address,
  input  logic [DataWidth-1:0] mem_write_data,
  input  logic [WordSize-1:0]  mem_write_strobe,
  output logic                 mem_ready,
  output logic [DataWidth-1:0] mem_read_data,
  output logic                 ram_req,
  output logic                 ram_write_enable,
  output logic [AddrWidth-1:0] ram_address,
  output logic [DataWidth-1:0] ram_write_data,
  output logic [WordSize-1:0]  ram_write_strobe,
  input  logic                 ram_ack,
  input  logic [DataWidth-1:0] ram_read_data,
  output logic                 grant_mem
);

  localparam int StarveW = (StarveLimit < 1) ? 1 : $clog2(StarveLimit + 1);
  localparam logic [StarveW-1:0] StarveMax = StarveW'(StarveLimit);

  // state | meaning:  IDLE sample requests | BUSY wait for ram_ack | DONE pulse winner's ready
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StDone = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [StarveW-1:0]   starve_q, starve_d;
  logic                 ram_req_q, ram_req_d;
  logic                 ram_we_q, ram_we_d;
  logic [AddrWidth-1:0] ram_addr_q, ram_addr_d;
  logic [DataWidth-1:0] ram_wdata_q, ram_wdata_d;
  logic [WordSize-1:0]  ram_strb_q, ram_strb_d;
  logic                 grant_mem_q, grant_mem_d;
  logic                 if_ready_q, if_ready_d;
  logic                 mem_ready_q, mem_ready_d;
  logic [DataWidth-1:0] if_rdata_q, if_rdata_d;
  logic [DataWidth-1:0] mem_rdata_q, mem_rdata_d;

  logic pick_mem;

  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (if_req || mem_req) state_d = StBusy;
      StBusy:  if (ram_ack) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Fetch only overrides the data side once it has been starved the full limit.
  assign pick_mem = mem_req && !(if_req && (starve_q == StarveMax));

  always_comb begin
    starve_d    = starve_q;
    ram_req_d   = ram_req_q;
    ram_we_d    = ram_we_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    ram_strb_d  = ram_strb_q;
    grant_mem_d = grant_mem_q;
    if_ready_d  = 1'b0;
    mem_ready_d = 1'b0;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    case (state_q)
      StIdle: begin
        if (if_req || mem_req) begin
          ram_req_d   = 1'b1;
          grant_mem_d = pick_mem;
          if (pick_mem) begin
            ram_we_d    = mem_write_enable;
            ram_addr_d  = mem_address;
            ram_wdata_d = mem_write_data;
            ram_strb_d  = mem_write_strobe;
            if (if_req && (starve_q != StarveMax)) starve_d = starve_q + StarveW'(1);
          end else begin
            ram_we_d    = 1'b0;
            ram_addr_d  = if_address;
            ram_wdata_d = '0;
            ram_strb_d  = '0;
            starve_d    = '0;
          end
        end
      end
      StBusy: begin
        if (ram_ack) begin
          ram_req_d = 1'b0;
          if (grant_mem_q) begin
            mem_ready_d = 1'b1;
            if (!ram_we_q) mem_rdata_d = ram_read_data;
          end else begin
            if_ready_d = 1'b1;
            if_rdata_d = ram_read_data;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q    <= '0;
      ram_req_q   <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      ram_strb_q  <= '0;
      grant_mem_q <= 1'b0;
      if_ready_q  <= 1'b0;
      mem_ready_q <= 1'b0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
    end else begin
      starve_q    <= starve_d;
      ram_req_q   <= ram_req_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      ram_strb_q  <= ram_strb_d;
      grant_mem_q <= grant_mem_d;
      if_ready_q  <= if_ready_d;
      mem_ready_q <= mem_ready_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  assign ram_req          = ram_req_q;
  assign ram_write_enable = ram_we_q;
  assign ram_address      = ram_addr_q;
  assign ram_write_data   = ram_wdata_q;
  assign ram_write_strobe = ram_strb_q;
  assign grant_mem        = grant_mem_q;
  assign if_ready         = if_ready_q;
  assign mem_ready        = mem_ready_q;
  assign if_read_data     = if_rdata_q;
  assign mem_read_data    = mem_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a randomized
// run against a transaction-level reference model.
module tb_mem_port_arbiter;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int WS = 4;
  localparam int SL = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req;
  logic [AW-1:0] if_address;
  logic          if_ready;
  logic [DW-1:0] if_read_data;
  logic          mem_req;
  logic          mem_write_enable;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_write_data;
  logic [WS-1:0] mem_write_strobe;
  logic          mem_ready;
  logic [DW-1:0] mem_read_data;
  logic          ram_req;
  logic          ram_write_enable;
  logic [AW-1:0] ram_address;
  logic [DW-1:0] ram_write_data;
  logic [WS-1:0] ram_write_strobe;
  logic          ram_ack;
  logic [DW-1:0] ram_read_data;
  logic          grant_mem;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .DataWidth(DW), .AddrWidth(AW), .WordSize(WS), .StarveLimit(SL)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_address(if_address), .if_ready(if_ready), .if_read_data(if_read_data),
    .mem_req(mem_req), .mem_write_enable(mem_write_enable), .mem_address(mem_address),
    .mem_write_data(mem_write_data), .mem_write_strobe(mem_write_strobe),
    .mem_ready(mem_ready), .mem_read_data(mem_read_data),
    .ram_req(ram_req), .ram_write_enable(ram_write_enable), .ram_address(ram_address),
    .ram_write_data(ram_write_data), .ram_write_strobe(ram_write_strobe),
    .ram_ack(ram_ack), .ram_read_data(ram_read_data), .grant_mem(grant_mem)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if_req = 1'b0; if_address = '0;
    mem_req = 1'b0; mem_write_enable = 1'b0; mem_address = '0;
    mem_write_data = '0; mem_write_strobe = '0;
    ram_ack = 1'b0; ram_read_data = '0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    rst = 1'b0;
  endtask

  function automatic logic [136:0] all_outs();
    return {if_ready, if_read_data, mem_ready, mem_read_data, ram_req, ram_write_enable,
            ram_address, ram_write_data, ram_write_strobe, grant_mem};
  endfunction

  task automatic wait_ram_req(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (ram_req === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    ram_ack = 1'b1; ram_read_data = 32'hFFFF_FFFF;
    tick();
    n_checks++;
    if (all_outs() !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got %h expected 0", all_outs());
    end
    rst = 1'b0; ram_ack = 1'b0;
    tick();
    tick();
    n_checks++;
    if (all_outs() !== '0) begin
      n_fail++; $display("FAIL reset_idle: got %h expected 0", all_outs());
    end
  endtask

  task automatic test_fetch_only();
    apply_reset();
    if_req = 1'b1; if_address = 32'h100;
    mem_write_data = 32'h1234_5678; mem_write_strobe = 4'b1111;
    tick();
    n_checks++;
    if ({ram_req, ram_write_enable, ram_write_strobe, grant_mem, ram_address, if_ready} !==
        {1'b1, 1'b0, 4'b0000, 1'b0, 32'h100, 1'b0}) begin
      n_fail++;
      $display("FAIL fetch_issue: got req=%b we=%b strb=%b gm=%b addr=%h rdy=%b expected 1 0 0000 0 00000100 0",
               ram_req, ram_write_enable, ram_write_strobe, grant_mem, ram_address, if_ready);
    end
    ram_ack = 1'b1; ram_read_data = 32'hDEAD_BEEF;
    tick();
    ram_ack = 1'b0; ram_read_data = '0; if_req = 1'b0;
    n_checks++;
    if ({if_ready, mem_ready, ram_req} !== 3'b100) begin
      n_fail++; $display("FAIL fetch_ready: got if_rdy/mem_rdy/req=%b expected 100", {if_ready, mem_ready, ram_req});
    end
    n_checks++;
    if (if_read_data !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL fetch_data: got %h expected deadbeef", if_read_data);
    end
    tick();
    n_checks++;
    if ({if_ready, if_read_data} !== {1'b0, 32'hDEAD_BEEF}) begin
      n_fail++; $display("FAIL fetch_hold: got rdy=%b data=%h expected 0 deadbeef", if_ready, if_read_data);
    end
  endtask

  task automatic test_data_write();
    apply_reset();
    mem_req = 1'b1; mem_write_enable = 1'b1; mem_address = 32'h203;
    mem_write_data = 32'hAB00_0000; mem_write_strobe = 4'b1000;
    tick();
    n_checks++;
    if ({ram_req, ram_write_enable, ram_address, ram_write_data, ram_write_strobe, grant_mem} !==
        {1'b1, 1'b1, 32'h203, 32'hAB00_0000, 4'b1000, 1'b1}) begin
      n_fail++;
      $display("FAIL write_issue: got req=%b we=%b addr=%h wd=%h strb=%b gm=%b expected 1 1 00000203 ab000000 1000 1",
               ram_req, ram_write_enable, ram_address, ram_write_data, ram_write_strobe, grant_mem);
    end
    mem_address = 32'hFFF0; mem_write_data = 32'h55; mem_write_strobe = 4'b0001;
    tick();
    n_checks++;
    if ({ram_req, ram_address, ram_write_data, ram_write_strobe, mem_ready} !==
        {1'b1, 32'h203, 32'hAB00_0000, 4'b1000, 1'b0}) begin
      n_fail++;
      $display("FAIL write_stable: got req=%b addr=%h wd=%h strb=%b rdy=%b expected 1 00000203 ab000000 1000 0",
               ram_req, ram_address, ram_write_data, ram_write_strobe, mem_ready);
    end
    tick();
    ram_ack = 1'b1; ram_read_data = 32'hCAFE_F00D;
    tick();
    ram_ack = 1'b0; mem_req = 1'b0;
    n_checks++;
    if ({mem_ready, if_ready, ram_req, mem_read_data} !== {3'b100, 32'h0}) begin
      n_fail++; $display("FAIL write_ready: got rdy=%b if_rdy=%b req=%b rd=%h expected 1 0 0 00000000",
                         mem_ready, if_ready, ram_req, mem_read_data);
    end
    tick();
    n_checks++;
    if (mem_ready !== 1'b0) begin
      n_fail++; $display("FAIL write_pulse: got mem_ready=%b expected 0", mem_ready);
    end
  endtask

  task automatic test_starvation();
    bit ok;
    bit exp_m;
    int lat;
    apply_reset();
    if_req = 1'b1; if_address = 32'h1000;
    mem_req = 1'b1; mem_write_enable = 1'b0; mem_address = 32'h2000;
    for (int g = 0; g < 10; g++) begin
      exp_m = (g % 5) != 4;
      wait_ram_req(8, ok);
      n_checks++;
      if (!ok) begin
        n_fail++; $display("FAIL starve_timeout: got no ram_req for grant %0d expected one", g);
        break;
      end
      n_checks++;
      if ({grant_mem, ram_address} !== {exp_m, exp_m ? 32'h2000 : 32'h1000}) begin
        n_fail++; $display("FAIL starve_grant%0d: got gm=%b addr=%h expected gm=%b", g, grant_mem, ram_address, exp_m);
      end
      lat = $urandom_range(1, 3);
      for (int l = 1; l < lat; l++) tick();
      ram_ack = 1'b1; ram_read_data = $urandom;
      tick();
      ram_ack = 1'b0;
      n_checks++;
      if ({if_ready, mem_ready} !== {!exp_m, exp_m}) begin
        n_fail++; $display("FAIL starve_ready%0d: got if/mem=%b%b expected %b%b", g, if_ready, mem_ready, !exp_m, exp_m);
      end
    end
    idle_inputs();
    tick();
    tick();
  endtask

  task automatic test_spurious_ack();
    apply_reset();
    ram_ack = 1'b1; ram_read_data = 32'h1111_1111;
    tick();
    tick();
    ram_ack = 1'b0;
    n_checks++;
    if (all_outs() !== '0) begin
      n_fail++; $display("FAIL idle_ack: got %h expected 0", all_outs());
    end
    if_req = 1'b1; if_address = 32'h300;
    tick();
    ram_ack = 1'b1; ram_read_data = 32'h2222_2222;
    tick();
    if_req = 1'b0; ram_read_data = 32'h3333_3333;
    tick();
    ram_ack = 1'b0;
    n_checks++;
    if ({if_ready, mem_ready, ram_req, if_read_data} !== {3'b000, 32'h2222_2222}) begin
      n_fail++; $display("FAIL done_ack: got if=%b mem=%b req=%b data=%h expected 0 0 0 22222222",
                         if_ready, mem_ready, ram_req, if_read_data);
    end
    tick();
    n_checks++;
    if ({ram_req, if_ready, if_read_data} !== {2'b00, 32'h2222_2222}) begin
      n_fail++; $display("FAIL done_ack_after: got req=%b rdy=%b data=%h expected 0 0 22222222",
                         ram_req, if_ready, if_read_data);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    mem_req = 1'b1; mem_write_enable = 1'b1; mem_address = 32'h500;
    mem_write_data = 32'h77; mem_write_strobe = 4'b1111;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; mem_req = 1'b0;
    ram_ack = 1'b1; ram_read_data = 32'h99;
    n_checks++;
    if (all_outs() !== '0) begin
      n_fail++; $display("FAIL midrst_outputs: got %h expected 0", all_outs());
    end
    tick();
    ram_ack = 1'b0;
    n_checks++;
    if (all_outs() !== '0) begin
      n_fail++; $display("FAIL midrst_late_ack: got %h expected 0", all_outs());
    end
    if_req = 1'b1; if_address = 32'h600;
    tick();
    n_checks++;
    if ({ram_req, grant_mem, ram_address} !== {2'b10, 32'h600}) begin
      n_fail++; $display("FAIL midrst_next_issue: got req=%b gm=%b addr=%h expected 1 0 00000600",
                         ram_req, grant_mem, ram_address);
    end
    ram_ack = 1'b1; ram_read_data = 32'hA5A5_A5A5;
    tick();
    if_req = 1'b0; ram_ack = 1'b0;
    n_checks++;
    if ({if_ready, if_read_data} !== {1'b1, 32'hA5A5_A5A5}) begin
      n_fail++; $display("FAIL midrst_next_done: got rdy=%b data=%h expected 1 a5a5a5a5", if_ready, if_read_data);
    end
    tick();
  endtask

  task automatic test_read_while_fetch_waits();
    apply_reset();
    if_req = 1'b1; if_address = 32'h700;
    mem_req = 1'b1; mem_write_enable = 1'b0; mem_address = 32'h40; mem_write_strobe = 4'b0000;
    tick();
    n_checks++;
    if ({ram_req, grant_mem, ram_write_enable, ram_address} !== {3'b110, 32'h40}) begin
      n_fail++; $display("FAIL rd_issue: got req=%b gm=%b we=%b addr=%h expected 1 1 0 00000040",
                         ram_req, grant_mem, ram_write_enable, ram_address);
    end
    ram_ack = 1'b1; ram_read_data = 32'h1234_5678;
    tick();
    ram_ack = 1'b0; mem_req = 1'b0;
    n_checks++;
    if ({mem_ready, if_ready, mem_read_data, if_read_data} !== {2'b10, 32'h1234_5678, 32'h0}) begin
      n_fail++; $display("FAIL rd_done: got mrdy=%b irdy=%b mrd=%h ird=%h expected 1 0 12345678 00000000",
                         mem_ready, if_ready, mem_read_data, if_read_data);
    end
    tick();
    tick();
    n_checks++;
    if ({ram_req, grant_mem, ram_write_strobe, ram_address} !== {2'b10, 4'b0000, 32'h700}) begin
      n_fail++; $display("FAIL rd_then_fetch: got req=%b gm=%b strb=%b addr=%h expected 1 0 0000 00000700",
                         ram_req, grant_mem, ram_write_strobe, ram_address);
    end
    ram_ack = 1'b1; ram_read_data = 32'hFEED_FACE;
    tick();
    ram_ack = 1'b0; if_req = 1'b0;
    n_checks++;
    if ({if_ready, if_read_data, mem_read_data} !== {1'b1, 32'hFEED_FACE, 32'h1234_5678}) begin
      n_fail++; $display("FAIL rd_fetch_done: got rdy=%b ird=%h mrd=%h expected 1 feedface 12345678",
                         if_ready, if_read_data, mem_read_data);
    end
    tick();
  endtask

  // Transaction-level model: a transaction occupies the port from grant until the
  // cycle after its ack; the port samples requests again one cycle after ready.
  task automatic test_random(input int cycles);
    bit            in_flight = 1'b0;
    bit            exp_m = 1'b0;
    bit            e_we = 1'b0;
    bit            if_pend = 1'b0;
    bit            mem_pend = 1'b0;
    bit            exp_if_rdy = 1'b0;
    bit            exp_mem_rdy = 1'b0;
    bit            grant_now, ack_now;
    int            starve = 0;
    int            lat_left = 0;
    logic [AW-1:0] e_addr = '0;
    logic [DW-1:0] e_wdata = '0;
    logic [WS-1:0] e_strb = '0;
    logic [DW-1:0] e_if_rd = '0;
    logic [DW-1:0] e_mem_rd = '0;
    logic [DW-1:0] ack_data;
    apply_reset();
    for (int c = 0; c < cycles; c++) begin
      if (!if_pend && $urandom_range(0, 1) == 0) begin
        if_pend = 1'b1; if_address = $urandom;
      end
      if (!mem_pend && $urandom_range(0, 1) == 0) begin
        mem_pend = 1'b1; mem_write_enable = 1'($urandom); mem_address = $urandom;
        mem_write_data = $urandom; mem_write_strobe = 4'($urandom);
      end
      if_req = if_pend; mem_req = mem_pend;
      if (in_flight) begin
        ram_ack = (lat_left == 0);
        if (lat_left > 0) lat_left--;
      end else begin
        ram_ack = ($urandom_range(0, 3) == 0);
      end
      ram_read_data = $urandom;
      ack_data = ram_read_data;
      ack_now = in_flight && ram_ack;
      grant_now = !in_flight && !(exp_if_rdy || exp_mem_rdy) && (if_pend || mem_pend);
      tick();
      exp_if_rdy = 1'b0; exp_mem_rdy = 1'b0;
      if (grant_now) begin
        exp_m = mem_pend && !(if_pend && starve == SL);
        if (exp_m && if_pend) starve = (starve < SL) ? starve + 1 : SL;
        else if (!exp_m) starve = 0;
        e_we = exp_m ? mem_write_enable : 1'b0;
        e_addr = exp_m ? mem_address : if_address;
        e_strb = exp_m ? mem_write_strobe : '0;
        e_wdata = mem_write_data;
        in_flight = 1'b1;
        lat_left = $urandom_range(0, 3);
      end else if (ack_now) begin
        in_flight = 1'b0;
        if (exp_m) begin
          exp_mem_rdy = 1'b1; mem_pend = 1'b0;
          if (!e_we) e_mem_rd = ack_data;
        end else begin
          exp_if_rdy = 1'b1; if_pend = 1'b0; e_if_rd = ack_data;
        end
      end
      n_checks++;
      if ({ram_req, if_ready, mem_ready, grant_mem} !== {in_flight, exp_if_rdy, exp_mem_rdy, exp_m}) begin
        n_fail++; $display("FAIL rnd_ctrl c%0d: got req/ir/mr/gm=%b expected %b", c,
                           {ram_req, if_ready, mem_ready, grant_mem}, {in_flight, exp_if_rdy, exp_mem_rdy, exp_m});
      end
      n_checks++;
      if ({if_read_data, mem_read_data} !== {e_if_rd, e_mem_rd}) begin
        n_fail++; $display("FAIL rnd_rdata c%0d: got %h %h expected %h %h", c, if_read_data, mem_read_data, e_if_rd, e_mem_rd);
      end
      if (in_flight) begin
        n_checks++;
        if ({ram_write_enable, ram_address, ram_write_strobe} !== {e_we, e_addr, e_strb}) begin
          n_fail++; $display("FAIL rnd_ram c%0d: got we=%b addr=%h strb=%b expected %b %h %b", c,
                             ram_write_enable, ram_address, ram_write_strobe, e_we, e_addr, e_strb);
        end
        if (exp_m) begin
          n_checks++;
          if (ram_write_data !== e_wdata) begin
            n_fail++; $display("FAIL rnd_wdata c%0d: got %h expected %h", c, ram_write_data, e_wdata);
          end
        end
      end
    end
    idle_inputs();
    tick();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_fetch_only();
    test_data_write();
    test_starvation();
    test_spurious_ack();
    test_reset_mid();
    test_read_while_fetch_waits();
    test_random(800);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
